// File: rtl/serial_mac_responder_pkg.sv
// Shared types and defaults for the serial shift-add MAC responder.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned A_W_DEF   = 4;
  localparam int unsigned B_W_DEF   = 4;
  localparam int unsigned ACC_W_DEF = 8;

  // The accumulator must be able to hold a full product without losing bits.
  function automatic bit widths_ok(input int unsigned a_w, input int unsigned b_w,
                                   input int unsigned acc_w);
    return acc_w >= (a_w + b_w);
  endfunction

endpackage

// File: rtl/serial_mac_responder_if.sv
// Start/busy MAC handshake bundle between the sequencer (master) and the MAC (slave).
interface serial_mac_responder_if
  import mac_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
);

  logic                    ena;
  logic                    start;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic signed [ACC_W-1:0] acc_init;
  logic                    busy;
  logic                    done;
  logic signed [ACC_W-1:0] acc_out;
  logic                    ovf;

  modport master (
    output ena, start, a, b, acc_init,
    input  busy, done, acc_out, ovf
  );

  modport slave (
    input  ena, start, a, b, acc_init,
    output busy, done, acc_out, ovf
  );

endinterface

// File: rtl/serial_mac_responder_datapath.sv
// Captured operands, ACC_W+1 working sum and bit counter for the serial signed MAC.
module serial_mac_datapath
  import mac_pkg::*;
#(
  parameter  int unsigned A_W   = A_W_DEF,
  parameter  int unsigned B_W   = B_W_DEF,
  parameter  int unsigned ACC_W = ACC_W_DEF,
  localparam int unsigned IDX_W = $clog2(B_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic                    last_bit_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  input  logic signed [ACC_W-1:0] acc_init_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic signed [ACC_W:0]   sum_nxt_o
);

  logic signed [A_W-1:0] a_q, a_d;
  logic signed [B_W-1:0] b_q, b_d;
  logic signed [ACC_W:0] sum_q, sum_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic signed [ACC_W:0] a_ext;
  logic signed [ACC_W:0] addend;
  logic signed [ACC_W:0] sum_step;
  logic                  bit_set;

  always_comb begin
    a_ext   = {{(ACC_W + 1 - A_W){a_q[A_W-1]}}, a_q};
    addend  = a_ext << idx_q;
    bit_set = |(b_q & (B_W'(1) << idx_q));
    // The multiplier's MSB carries negative weight, so its partial product is subtracted.
    sum_step = sum_q;
    if (bit_set) begin
      sum_step = last_bit_i ? (sum_q - addend) : (sum_q + addend);
    end

    a_d   = a_q;
    b_d   = b_q;
    sum_d = sum_q;
    idx_d = idx_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      sum_d = {acc_init_i[ACC_W-1], acc_init_i};
      idx_d = '0;
    end else if (step_i) begin
      sum_d = sum_step;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      idx_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o     = idx_q;
  assign sum_nxt_o = sum_step;

endmodule

// File: rtl/serial_mac_responder.sv
// Multi-cycle signed MAC responder: acc_out = acc_init + a*b, one multiplier bit per enabled cycle.
module serial_mac_responder
  import mac_pkg::*;
#(
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_mac_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(B_W + 1);

  if (!widths_ok(A_W, B_W, ACC_W)) begin : g_width_check
    $error("serial_mac_responder: ACC_W must be >= A_W + B_W");
  end

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic   ovf_q, ovf_d;

  logic                  load;
  logic                  step;
  logic                  last_bit;
  logic [IDX_W-1:0]      idx;
  logic signed [ACC_W:0] sum_nxt;

  assign last_bit = (idx == IDX_W'(B_W - 1));

  serial_mac_datapath #(
    .A_W   (A_W),
    .B_W   (B_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .last_bit_i (last_bit),
    .a_i        (bus.a),
    .b_i        (bus.b),
    .acc_init_i (bus.acc_init),
    .idx_o      (idx),
    .sum_nxt_o  (sum_nxt)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    step      = 1'b0;

    if (bus.ena) begin
      unique case (state_q)
        IDLE, DONE: begin
          done_d = 1'b0;
          if (bus.start) begin
            load    = 1'b1;
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        CALC: begin
          step = 1'b1;
          if (last_bit) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            acc_out_d = sum_nxt[ACC_W-1:0];
            ovf_d     = sum_nxt[ACC_W] ^ sum_nxt[ACC_W-1];
            state_d   = DONE;
          end
        end
        default: begin
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.acc_out = acc_out_q;
  assign bus.ovf     = ovf_q;

endmodule
